imm_extender_pipe: RTL

Registered, parametrised immediate-extension stage for the MIPS datapath, placed between instruction decode and the ALU operand mux. It accepts an IN_W-bit immediate plus a mode select and produces an OUT_W-bit operand: sign-extended, zero-extended, LUI-shifted or branch-offset. Transfers use valid/ready handshakes on both sides, with a one-entry skid buffer so the stage runs at full throughput under back-pressure. A TAG_W-bit tag (destination register / instruction ID) travels with each result.

---
 rtl/imm_ext_pkg.sv | 35 +++
 rtl/imm_extender_pipe_skid.sv | 54 +++++
 rtl/imm_extender_pipe.sv | 52 +++++
 3 files changed

// File: rtl/imm_ext_pkg.sv
// Shared types and the immediate-extension function for the imm_extender_pipe stage.
// The function is width-generic: immediates and results travel in MAX_W-bit containers.
package imm_ext_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    SIGN   = 2'b00,
    ZERO   = 2'b01,
    LUI    = 2'b10,
    BRANCH = 2'b11
  } ext_mode_t;

  // Bits above out_w in the return value are don't-care; callers slice them off.
  function automatic logic [MAX_W-1:0] ext_apply(input logic [MAX_W-1:0] imm,
                                                 input ext_mode_t        mode,
                                                 input int               in_w,
                                                 input int               out_w);
    logic [MAX_W-1:0] sx;
    logic [MAX_W-1:0] zx;
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) begin
      sx[i] = (i < in_w) ? imm[i] : imm[in_w-1];
      zx[i] = (i < in_w) ? imm[i] : 1'b0;
    end
    case (mode)
      SIGN:    r = sx;
      ZERO:    r = zx;
      LUI:     r = zx << (out_w - in_w);
      default: r = sx << 2;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_extender_pipe_skid.sv
// Two-slot valid/ready register stage (main slot + skid slot), latency 1 cycle.
// in_ready is the registered inverse of skid_v, so out_ready has no combinational path to in_ready.
module ext_skid_buffer #(
  parameter int W = 38
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_v;
  logic [W-1:0] main_d;
  logic         skid_v;
  logic [W-1:0] skid_d;
  logic         accept;
  logic         drain;

  assign accept    = in_valid && !skid_v;
  assign drain     = main_v && out_ready;
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      main_d <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (skid_v) begin
      // Both slots full: only a drain can move things, and no accept is possible.
      if (drain) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end
    end else if (accept) begin
      if (!main_v || drain) begin
        main_d <= in_data;
        main_v <= 1'b1;
      end else begin
        skid_d <= in_data;
        skid_v <= 1'b1;
      end
    end else if (drain) begin
      main_v <= 1'b0;
    end
  end

endmodule

// File: rtl/imm_extender_pipe.sv
// Registered immediate extender (sign/zero/LUI/branch) feeding the ALU operand mux.
// One cycle latency, full throughput; back-pressure absorbed by a one-entry skid slot.
module imm_extender_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  ext_mode_t        in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_neg
);

  localparam int W = OUT_W + TAG_W + 1;

  logic [MAX_W-1:0] ext_full;
  logic [OUT_W-1:0] ext;
  logic             ext_unused;
  logic [W-1:0]     pay_in;
  logic [W-1:0]     pay_out;

  assign ext_full   = ext_apply(MAX_W'(in_imm), in_mode, IN_W, OUT_W);
  assign ext        = ext_full[OUT_W-1:0];
  assign ext_unused = ^ext_full[MAX_W-1:OUT_W];
  assign pay_in     = {ext[OUT_W-1], in_tag, ext};

  ext_skid_buffer #(.W(W)) u_skid (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pay_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pay_out)
  );

  assign out_neg  = pay_out[W-1];
  assign out_tag  = pay_out[OUT_W +: TAG_W];
  assign out_data = pay_out[OUT_W-1:0];

endmodule
